// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the framebuffer RAM between per-row line prefetch and a drawing client
// Ports: clk_pix/rst_pix clock and async reset; newline/sy line start from the timing generator;
//        mem_* framebuffer RAM port; lb_* line buffer fill port and bank; draw_* drawing client
//        access; busy while prefetching; fetch_overrun sticky error flag.
module vga_fb_arbiter #(
    parameter int FB_COLS    = 200,
    parameter int FB_ROWS    = 150,
    parameter int SCALE_LOG2 = 2,
    parameter int V_TOTAL    = 628,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 4
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              newline,
    input  logic [9:0]        sy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [7:0]        lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              lb_bank,
    input  logic              draw_req,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_gnt,
    output logic              draw_rvalid,
    output logic [DATA_W-1:0] draw_rdata,
    output logic              busy,
    output logic              fetch_overrun
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_n;
    logic [9:0] nxt;
    logic trig, idle, fetch, lb_v, rd_v;
    logic [7:0] col;
    logic [ADDR_W-1:0] base, addr_q;

    assign nxt = (sy == 10'(V_TOTAL - 1)) ? '0 : sy + 10'd1;
    assign trig = newline && nxt[SCALE_LOG2-1:0] == '0 && nxt < 10'(FB_ROWS << SCALE_LOG2);
    assign idle = state == IDLE;
    assign fetch = state == FETCH;
    assign busy = !idle;
    // gated by reset so the combinational grant is also 0 while reset is held
    assign draw_gnt = draw_req && idle && !trig && !rst_pix;
    // addr_q keeps the RAM address stable when nobody is using the port
    assign mem_addr = fetch ? base + ADDR_W'(col) : draw_gnt ? draw_addr : addr_q;
    assign mem_we = draw_gnt && draw_we;
    assign mem_wdata = draw_gnt ? draw_wdata : '0;
    assign lb_we = lb_v;
    assign lb_wdata = lb_v ? mem_rdata : '0;
    assign draw_rvalid = rd_v;
    assign draw_rdata = rd_v ? mem_rdata : '0;

    always_comb begin
        state_n = idle ? (trig ? FETCH : IDLE) :
                  fetch ? (col == 8'(FB_COLS - 1) ? DRAIN : FETCH) : IDLE;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            col           <= '0;
            base          <= '0;
            addr_q        <= '0;
            lb_v          <= 1'b0;
            lb_addr       <= '0;
            lb_bank       <= 1'b0;
            rd_v          <= 1'b0;
            fetch_overrun <= 1'b0;
        end else begin
            col    <= fetch ? col + 8'd1 : '0;
            addr_q <= mem_addr;
            lb_v   <= fetch;
            rd_v   <= draw_gnt && !draw_we;
            if (fetch) lb_addr <= col;
            if (idle && trig) begin
                base    <= ADDR_W'(nxt >> SCALE_LOG2) * ADDR_W'(FB_COLS);
                lb_bank <= !lb_bank;
            end
            if (!idle && trig) fetch_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for vga_fb_arbiter with a RAM model and a row/grant reference model
module tb_vga_fb_arbiter;
    localparam int FB_COLS = 200;
    localparam int AW = 15;
    localparam int DW = 4;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b0;
    logic newline = 1'b0;
    logic [9:0] sy = '0;
    logic [AW-1:0] mem_addr, draw_addr = '0;
    logic mem_we, lb_we, lb_bank, draw_gnt, draw_rvalid, busy, fetch_overrun;
    logic draw_req = 1'b0;
    logic draw_we = 1'b0;
    logic [DW-1:0] mem_wdata, lb_wdata, draw_rdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] draw_wdata = '0;
    logic [7:0] lb_addr;

    always #5 clk_pix = ~clk_pix;

    vga_fb_arbiter dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .newline(newline), .sy(sy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata), .lb_bank(lb_bank),
        .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
        .draw_gnt(draw_gnt), .draw_rvalid(draw_rvalid), .draw_rdata(draw_rdata),
        .busy(busy), .fetch_overrun(fetch_overrun)
    );

    typedef struct {bit bank; int col; int data;} lb_t;
    lb_t exp_lb[$];
    int exp_rd[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, fs = -1000, mbase = 0, last = 0;
    bit mbank = 1'b0, movr = 1'b0;
    int salt = 0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit wr_done [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a ^ (a >> 4) ^ (a >> 9) ^ salt);
    endfunction

    // single-port RAM, read data one cycle after the address
    always @(posedge clk_pix) begin
        mem_rdata <= wr_done[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            wr_done[mem_addr] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit rule(input int s);
        int n;
        n = (s == 627) ? 0 : s + 1;
        return (n % 4 == 0) && (n < 600);
    endfunction

    // monitor: pops expectations whenever the DUT presents line-buffer or draw read data
    lb_t e;
    int er;
    always @(negedge clk_pix) begin
        if (!rst_pix) begin
            if (lb_we) begin
                if (exp_lb.size() == 0) chk("lb_unexpected", 1, 0);
                else begin
                    e = exp_lb.pop_front();
                    chk("lb_addr", int'(lb_addr), e.col);
                    chk("lb_wdata", int'(lb_wdata), e.data);
                    chk("lb_bank", int'(lb_bank), int'(e.bank));
                end
            end
            if (draw_rvalid) begin
                if (exp_rd.size() == 0) chk("rvalid_unexpected", 1, 0);
                else begin
                    er = exp_rd.pop_front();
                    chk("draw_rdata", int'(draw_rdata), er);
                end
            end
        end
    end

    task automatic step(input bit nl, input int s, input bit rq, input bit we, input int a, input int wd);
        bit trig, bz, eg;
        int n;
        @(negedge clk_pix);
        newline = nl; sy = 10'(s); draw_req = rq; draw_we = we;
        draw_addr = AW'(a); draw_wdata = DW'(wd);
        #1;
        trig = nl && rule(s);
        bz = cyc >= fs && cyc < fs + 201;
        eg = rq && !bz && !trig;
        chk("busy", int'(busy), int'(bz));
        chk("draw_gnt", int'(draw_gnt), int'(eg));
        chk("fetch_overrun", int'(fetch_overrun), int'(movr));
        if (cyc >= fs && cyc < fs + 200) begin
            chk("fetch_addr", int'(mem_addr), mbase + cyc - fs);
            chk("fetch_we", int'(mem_we), 0);
            last = mbase + cyc - fs;
        end else if (eg) begin
            chk("draw_mem_addr", int'(mem_addr), a);
            chk("draw_mem_we", int'(mem_we), int'(we));
            if (we) chk("mem_wdata", int'(mem_wdata), wd);
            last = a;
            if (we) ref_mem[a] = DW'(wd);
            else exp_rd.push_back(int'(ref_mem[a]));
        end else begin
            chk("hold_addr", int'(mem_addr), last);
            chk("idle_we", int'(mem_we), 0);
        end
        if (trig && bz) movr = 1'b1;
        else if (trig) begin
            n = (s == 627) ? 0 : s + 1;
            mbase = (n / 4) * FB_COLS;
            mbank = !mbank;
            fs = cyc + 1;
            for (int c = 0; c < FB_COLS; c++)
                exp_lb.push_back('{bank: mbank, col: c, data: int'(ref_mem[mbase + c])});
        end
        cyc++;
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk_pix);
        rst_pix = 1'b1; newline = 1'b0; draw_req = 1'b1; draw_we = 1'b0;
        #1;
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_lb_we", int'(lb_we), 0);
        chk("rst_lb_addr", int'(lb_addr), 0);
        chk("rst_lb_wdata", int'(lb_wdata), 0);
        chk("rst_lb_bank", int'(lb_bank), 0);
        chk("rst_draw_gnt", int'(draw_gnt), 0);
        chk("rst_draw_rvalid", int'(draw_rvalid), 0);
        chk("rst_draw_rdata", int'(draw_rdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(fetch_overrun), 0);
        repeat (hold) @(negedge clk_pix);
        rst_pix = 1'b0; draw_req = 1'b0;
        exp_lb.delete(); exp_rd.delete();
        fs = -1000; mbank = 1'b0; movr = 1'b0; last = 0;
    endtask

    initial begin
        salt = int'($urandom);
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
        do_reset(3);
        idle_steps(2);
        // row 1 fetch while a draw read is held off until T+202
        step(1, 3, 1, 0, 'h1234, 0);
        for (int i = 0; i < 202; i++) step(0, 0, 1, 0, 'h1234, 0);
        idle_steps(3);
        // no-fetch lines, then frame wrap to row 0
        step(1, 599, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0);
        idle_steps(2);
        step(1, 627, 0, 0, 0, 0);
        idle_steps(205);
        // back-to-back draw write then read
        step(0, 0, 1, 1, 'h10, 'hA);
        step(0, 0, 1, 0, 'h10, 0);
        idle_steps(3);
        // reset in the middle of a fetch, then a normal fetch afterwards
        step(1, 11, 0, 0, 0, 0);
        idle_steps(49);
        do_reset(2);
        step(1, 3, 0, 0, 0, 0);
        idle_steps(205);
        // second trigger during a burst
        step(1, 7, 0, 0, 0, 0);
        idle_steps(99);
        step(1, 15, 0, 0, 0, 0);
        idle_steps(105);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 29) == 0, int'($urandom_range(0, 627)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range('h10, 'h17)) : int'($urandom_range(0, (1 << AW) - 1)),
                 int'($urandom_range(0, 15)));
        end
        idle_steps(210);
        chk("lb_queue_left", exp_lb.size(), 0);
        chk("rd_queue_left", exp_rd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates the single-port framebuffer RAM between display line prefetch and a drawing client, in the pixel clock domain. On each `newline` pulse from the VGA timing generator that starts a new framebuffer row, it bursts that row into one bank of a double-buffered line buffer, ahead of the scanout that needs it. The drawing client (tangram renderer) is granted RAM cycles only while no prefetch is in progress. The framebuffer is downscaled by 2^SCALE_LOG2 in both axes relative to the 800×600 active area.

## Interface

Parameters:
- `FB_COLS`, 200: framebuffer columns, which is also the burst length.
- `FB_ROWS`, 150: framebuffer rows.
- `SCALE_LOG2`, 2: log2 of the screen lines per framebuffer row.
- `V_TOTAL`, 628: total lines per frame; the last line is V_TOTAL-1.
- `ADDR_W`, 15: RAM address width; must hold FB_COLS*FB_ROWS-1.
- `DATA_W`, 4: pixel width.

Ports:
- `clk_pix` in 1: pixel clock. One clock; reset is asynchronous and active-high.
- `rst_pix` in 1: asynchronous active-high reset.
- `newline` in 1: one-cycle pulse at line start, from the timing generator.
- `sy` in 10: current line, valid while `newline` is high.
- `mem_addr` out ADDR_W: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data, returned 1 cycle after the address.
- `lb_we` out 1: line buffer write strobe.
- `lb_addr` out 8: line buffer column.
- `lb_wdata` out DATA_W: line buffer data.
- `lb_bank` out 1: bank being filled; scanout reads `~lb_bank`.
- `draw_req` in 1: drawing client requests one RAM access.
- `draw_we` in 1: 1 means write, 0 means read.
- `draw_addr` in ADDR_W: drawing client address.
- `draw_wdata` in DATA_W: drawing client write data.
- `draw_gnt` out 1: access is performed this cycle (combinational).
- `draw_rvalid` out 1: one cycle after a granted read.
- `draw_rdata` out DATA_W: read data, valid with `draw_rvalid`.
- `busy` out 1: high in FETCH or DRAIN.
- `fetch_overrun` out 1: sticky error flag, cleared only by reset.

## Operation

- Define `nxt = (sy == V_TOTAL-1) ? 0 : sy+1`.
- A fetch is triggered when `newline` is high, `nxt[SCALE_LOG2-1:0] == 0`, and `nxt < FB_ROWS << SCALE_LOG2`.
  - On trigger, latch `row = nxt >> SCALE_LOG2`.
  - On trigger, toggle `lb_bank`.
- The FSM has three states:
  - IDLE → FETCH on trigger; `col` is cleared to 0.
  - FETCH: drive `mem_addr = row*FB_COLS + col` with `mem_we = 0`, and increment `col`. When `col == FB_COLS-1`, go to DRAIN.
  - DRAIN: one cycle for the last read to land, then go to IDLE.
- Line buffer write, one cycle after each fetch read:
  - `lb_we = 1`, `lb_addr` = column issued one cycle earlier, `lb_wdata = mem_rdata`.
  - Implemented as a registered valid/column pipe.
- Drawing client access:
  - `draw_gnt = draw_req & (state == IDLE) & ~trigger`.
  - When granted, the RAM is driven from the `draw_*` inputs.
  - A request that is not granted must be held by the client; there is no queuing.
  - For a granted read, `draw_rvalid` pulses on the next cycle with `draw_rdata = mem_rdata`.
- Priority: display fetch always wins. A trigger in the same cycle as `draw_req` gives `draw_gnt = 0`.
- Overrun: a trigger while in FETCH or DRAIN sets `fetch_overrun`, and the trigger is ignored. This cannot occur with the 1056-cycle line.
- Row address arithmetic is exact with no wrap. `row*FB_COLS + col` fits in ADDR_W by construction; the implementation may use a multiplier or an accumulated base.
- When idle with no grant, `mem_addr` holds its last value and `mem_we = 0`.

## Timing

- Reset (asynchronous, any state, including mid-fetch):
  - FSM goes to IDLE and `col` to 0.
  - All outputs are 0: `mem_addr`, `mem_we`, `mem_wdata`, `lb_we`, `lb_addr`, `lb_wdata`, `lb_bank`, `draw_gnt`, `draw_rvalid`, `draw_rdata`, `busy`, `fetch_overrun`.
  - Any partially written bank is left as is.
- Fetch timing, with the trigger `newline` at cycle T:
  - FETCH from T+1 to T+FB_COLS; reads are issued at T+1 … T+200.
  - `lb_we` is high from T+2 to T+201.
  - DRAIN at T+201; IDLE at T+202, where the first draw grant is possible.
  - `busy` is high from T+1 to T+201.
- Draw access: a write completes in the grant cycle. A read has 1-cycle latency, and reads may be granted back-to-back.
- Frame wrap: `sy == V_TOTAL-1` fetches row 0. `sy == 599` (nxt 600) does not fetch.

## Test plan

- Reset, then `newline` with `sy = 3` → fetch of row 1: `mem_addr` 200…399 on T+1…T+200; `lb_we` T+2…T+201 with `lb_addr` 0…199; `lb_bank = 1`; IDLE at T+202.
- `newline` with `sy = 627` → row 0 fetch, addresses 0…199. `sy = 599` or `sy = 4` → no fetch, and `busy` stays 0.
- Hold `draw_req = 1` read at `draw_addr = 0x1234` across a trigger → `draw_gnt = 0` from T through T+201. Grant at T+202, and `draw_rvalid` at T+203 with the RAM model's data.
- Back-to-back draw write to 0x10 = 0xA, then read of 0x10 → grants on 2 consecutive cycles; `draw_rdata = 0xA` one cycle after the read grant.
- Assert `rst_pix` at T+50 mid-fetch → all outputs 0 immediately. After release, the next trigger fetches normally and `lb_bank` toggles from 0.
- Force a second trigger at T+100 → `fetch_overrun = 1` (sticky), and the current burst completes unchanged.
